pwm_multi_core: RTL and testbench
=================================

Name: pwm_multi_core

Overview:
- Next-generation N-channel PWM generator.
- Each channel has its own period/duty counter and shadow-buffered configuration. New settings are applied glitch-free at period boundaries.
- Each channel selects edge-aligned or center-aligned mode and output polarity. A global sync input restarts all counters together.
- Sits between the register interface (config writes) and the pad/driver layer (pwm_out).

Parameters:
- N_CHANNELS, 4, number of independent PWM channels (1..32).
- WIDTH_PERIOD, 16, bit width of period and channel counters.
- WIDTH_DUTY, 16, bit width of duty; must be <= WIDTH_PERIOD.
- DEADTIME, 4, dead-time in clocks, used only with PWM_DEADTIME_EN; width = clog2(DEADTIME+1).

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ch_en  in  N_CHANNELS  per-channel run enable.
- sync  in  1  pulse; restarts every enabled counter at 0 on the next cycle.
- cfg_wr  in  N_CHANNELS  one-hot (or multi-hot) shadow write strobe.
- cfg_period  in  WIDTH_PERIOD  period value for written channel(s).
- cfg_duty  in  WIDTH_DUTY  duty value for written channel(s).
- cfg_center  in  1  mode bit: 1 = center-aligned, 0 = edge-aligned.
- cfg_invert  in  1  polarity bit: 1 = active-low output.
- pwm_out  out  N_CHANNELS  registered PWM outputs.
- period_end  out  N_CHANNELS  1-cycle pulse at each channel's period boundary.
- upd_pending  out  N_CHANNELS  shadow written but not yet active.

Behaviour:
- Reset values:
  - All counters, active and shadow registers cleared (period = duty = 0, edge mode, non-inverted).
  - pwm_out = 0, period_end = 0, upd_pending = 0, direction = up.
- Edge mode, period P:
  - Counter runs 0..P-1 and wraps. Cycle = P clocks.
  - Raw output = (counter < D).
  - Boundary = cycle where counter == P-1.
- Center mode, period P:
  - Counter runs up 0..P-1, then down P-1..0, then repeats. Cycle = 2P clocks; each endpoint is held for two cycles.
  - Raw output = (counter < D), giving a high time of 2D clocks centred on counter 0.
  - Boundary = last down-count cycle at 0.
- Duty limits:
  - D = 0: raw output is always 0.
  - D >= P: raw output is always 1.
  - Duty is zero-extended to WIDTH_PERIOD for comparison.
- Period limits:
  - P = 0: channel is idle. Counter held at 0, raw output 0, no period_end pulses.
  - P = 1: counter stays at 0 and period_end pulses every cycle.
- Output path:
  - pwm_out = raw XOR invert, registered. Latency is 1 clock from counter value to pin.
  - Disabled or idle channel drives the inactive level (= invert).
- Shadow update:
  - cfg_wr[i] captures period, duty, center and invert into channel i's shadow and sets upd_pending[i].
  - At the boundary, shadow is copied to active, upd_pending clears, and the counter restarts at 0 in the up direction.
- Simultaneous cfg_wr[i] and boundary: the incoming bus values go directly to active and upd_pending stays 0 (write wins).
- ch_en[i] low:
  - Counter held at 0, direction up, output inactive.
  - Shadow writes go straight to active (upd_pending stays 0).
- ch_en rising: counting starts at 0 on the next clock with the current active values.
- sync:
  - Every enabled channel's counter is forced to 0, direction up, on the next clock.
  - Pending shadows load at that point; period_end is not pulsed.
  - sync has priority over a coinciding natural boundary.
- Reset asserted mid-period: everything returns to reset values immediately (asynchronous); restart requires reconfiguration.
- Counters never exceed P-1. All arithmetic is unsigned; no overflow is possible.

Optional Feature:
- Macro: PWM_DEADTIME_EN.
- Defined:
  - Adds output pwm_out_n [N_CHANNELS], the complementary output.
  - A per-channel dead-time counter delays every rising edge of both pwm_out and pwm_out_n by DEADTIME clocks.
  - Falling edges are immediate. Both outputs are never active together.
  - A pulse shorter than DEADTIME is suppressed.
  - Reset and idle state: both outputs inactive.
- Undefined: pwm_out_n and the dead-time logic are absent; behaviour is as above.

Decomposition:
- Package pwm_multi_pkg holds:
  - typedef pwm_mode_e {PWM_EDGE, PWM_CENTER};
  - typedef struct pwm_cfg_t {period, duty, center, invert}, parameterised through package localparams;
  - constants for default widths.
- Sub-module pwm_channel: one counter, active/shadow config, compare, output register, optional dead-time.
- The top level generates N_CHANNELS instances and fans out sync and the cfg bus.

Test Plan:
- Reset, then write ch0 P=10 D=3 edge and enable -> pwm_out[0] high 3 / low 7 repeating; period_end every 10th clock.
- Write ch1 P=8 D=2 center -> pwm_out[1] high 4 of every 16 clocks, centred on counter 0.
- ch0 running P=10 D=3; write D=7 mid-period -> upd_pending[0]=1 until the boundary; the next period shows high 7; no glitch.
- Duty limits: D=0 -> constant 0; D=10 with P=10 -> constant 1; invert=1 flips both; P=0 -> inactive level, no period_end.
- Channels P=10 and P=7 desynchronised; pulse sync -> both counters at 0 the next cycle, rising edges aligned; period_end not pulsed.
- With PWM_DEADTIME_EN and DEADTIME=2: P=10 D=5 -> pwm_out high 3, pwm_out_n high 3, 2-clock gaps, never both high; assert reset_n mid-pulse -> both outputs low immediately.

Source files
------------

// File: rtl/pwm_multi_pkg.sv
// pwm_multi_pkg: shared types and default sizes for the multi-channel PWM core.
// The optional dead-time feature (macro PWM_DEADTIME_EN) uses the dead-time
// state type and the width helper defined here.
package pwm_multi_pkg;

  // Default sizes used by the top level and by configuration records.
  localparam int PWM_N_CHANNELS_DEF   = 4;
  localparam int PWM_WIDTH_PERIOD_DEF = 16;
  localparam int PWM_WIDTH_DUTY_DEF   = 16;
  localparam int PWM_DEADTIME_DEF     = 4;

  // Counting mode of a channel.
  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // One channel configuration record at the default widths.
  typedef struct packed {
    logic [PWM_WIDTH_PERIOD_DEF-1:0] period;
    logic [PWM_WIDTH_DUTY_DEF-1:0]   duty;
    pwm_mode_e                       center;
    logic                            invert;
  } pwm_cfg_t;

  // Which output the dead-time stage is currently trying to drive active.
  typedef enum logic [1:0] {
    DT_IDLE = 2'd0,
    DT_HIGH = 2'd1,
    DT_LOW  = 2'd2
  } pwm_dt_state_e;

  // Width of a counter that must be able to hold the value 'deadtime'.
  function automatic int pwmDtWidth(input int deadtime);
    return (deadtime < 1) ? 1 : $clog2(deadtime + 1);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM channel with shadow/active configuration, edge- or
// center-aligned counter, compare and registered output. With the macro
// PWM_DEADTIME_EN defined, a complementary output with dead-time insertion
// is added.
module pwm_channel
  import pwm_multi_pkg::*;
#(
  parameter int WIDTH_PERIOD = PWM_WIDTH_PERIOD_DEF,
  parameter int WIDTH_DUTY   = PWM_WIDTH_DUTY_DEF,
  parameter int DEADTIME     = PWM_DEADTIME_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    sync_i,
  input  logic                    wr_i,
  input  logic [WIDTH_PERIOD-1:0] period_i,
  input  logic [WIDTH_DUTY-1:0]   duty_i,
  input  logic                    center_i,
  input  logic                    invert_i,
  output logic                    pwm_o,
`ifdef PWM_DEADTIME_EN
  output logic                    pwm_n_o,
`endif
  output logic                    period_end_o,
  output logic                    upd_pending_o
);

  // Duty is compared against the period-wide counter, so it may not be wider.
  if ((WIDTH_DUTY > WIDTH_PERIOD) || (WIDTH_DUTY < 1) || (DEADTIME < 0)) begin : g_bad_params
    $error("pwm_channel: illegal parameter combination");
  end

  logic [WIDTH_PERIOD-1:0] actPeriod_q, actPeriod_d;
  logic [WIDTH_DUTY-1:0]   actDuty_q, actDuty_d;
  pwm_mode_e               actMode_q, actMode_d;
  logic                    actInvert_q, actInvert_d;
  logic [WIDTH_PERIOD-1:0] shdPeriod_q, shdPeriod_d;
  logic [WIDTH_DUTY-1:0]   shdDuty_q, shdDuty_d;
  pwm_mode_e               shdMode_q, shdMode_d;
  logic                    shdInvert_q, shdInvert_d;
  logic                    pending_q, pending_d;
  logic [WIDTH_PERIOD-1:0] cnt_q, cnt_d;
  logic                    dirDown_q, dirDown_d;
  logic                    out_q, out_d;
  logic                    periodEnd_q, periodEnd_d;

  logic                    running;
  logic [WIDTH_PERIOD-1:0] lastCnt;
  logic                    atTop;
  logic                    boundary;
  logic                    reload;
  logic                    applyNow;
  logic                    raw;

  // Decode where the counter is within its period and whether config may change now.
  always_comb begin
    running  = en_i && (actPeriod_q != '0);
    lastCnt  = actPeriod_q - 1'b1;
    atTop    = (cnt_q == lastCnt);
    if (actMode_q == PWM_CENTER) begin
      boundary = running && dirDown_q && (cnt_q == '0);
    end else begin
      boundary = running && atTop;
    end
    reload   = running && (sync_i || boundary);
    // A stopped or idle channel has no boundary to wait for, so writes apply at once.
    applyNow = !running || reload;
    raw      = running && (cnt_q < WIDTH_PERIOD'(actDuty_q));
  end

  // Advance the counter: wrap in edge mode, bounce with doubled endpoints in center mode.
  always_comb begin
    cnt_d     = cnt_q;
    dirDown_d = dirDown_q;
    if (!running || reload) begin
      cnt_d     = '0;
      dirDown_d = 1'b0;
    end else if (actMode_q == PWM_EDGE) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!dirDown_q) begin
      if (atTop) begin
        dirDown_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Route bus writes to shadow or active, and promote a pending shadow at a reload point.
  always_comb begin
    actPeriod_d = actPeriod_q;
    actDuty_d   = actDuty_q;
    actMode_d   = actMode_q;
    actInvert_d = actInvert_q;
    shdPeriod_d = shdPeriod_q;
    shdDuty_d   = shdDuty_q;
    shdMode_d   = shdMode_q;
    shdInvert_d = shdInvert_q;
    pending_d   = pending_q;
    if (wr_i && applyNow) begin
      actPeriod_d = period_i;
      actDuty_d   = duty_i;
      actMode_d   = pwm_mode_e'(center_i);
      actInvert_d = invert_i;
      pending_d   = 1'b0;
    end else if (wr_i) begin
      shdPeriod_d = period_i;
      shdDuty_d   = duty_i;
      shdMode_d   = pwm_mode_e'(center_i);
      shdInvert_d = invert_i;
      pending_d   = 1'b1;
    end else if (pending_q && applyNow) begin
      actPeriod_d = shdPeriod_q;
      actDuty_d   = shdDuty_q;
      actMode_d   = shdMode_q;
      actInvert_d = shdInvert_q;
      pending_d   = 1'b0;
    end
  end

`ifdef PWM_DEADTIME_EN
  localparam int            DT_W   = pwmDtWidth(DEADTIME);
  localparam logic [DT_W-1:0] DT_MAX = DT_W'(DEADTIME);

  pwm_dt_state_e   dtState_q, dtState_d;
  logic [DT_W-1:0] dtCnt_q, dtCnt_d;
  logic            outN_q, outN_d;
  logic            dtHigh;
  logic            dtLow;

  // Count how long the wanted drive state has been stable; an output only turns on once it reaches DEADTIME.
  always_comb begin
    if (!running) begin
      dtState_d = DT_IDLE;
    end else if (raw) begin
      dtState_d = DT_HIGH;
    end else begin
      dtState_d = DT_LOW;
    end
    if (dtState_d != dtState_q) begin
      dtCnt_d = '0;
    end else if (dtCnt_q != DT_MAX) begin
      dtCnt_d = dtCnt_q + 1'b1;
    end else begin
      dtCnt_d = dtCnt_q;
    end
    dtHigh = (dtState_d == DT_HIGH) && (dtCnt_d == DT_MAX);
    dtLow  = (dtState_d == DT_LOW) && (dtCnt_d == DT_MAX);
  end
`endif

  // Form the next pin levels and the boundary pulse; sync suppresses the pulse.
  always_comb begin
    periodEnd_d = boundary && !sync_i;
`ifdef PWM_DEADTIME_EN
    out_d  = dtHigh ^ actInvert_q;
    outN_d = dtLow ^ actInvert_q;
`else
    out_d  = raw ^ actInvert_q;
`endif
  end

  // State registers; reset returns the channel to an idle, non-inverted edge configuration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      actPeriod_q <= '0;
      actDuty_q   <= '0;
      actMode_q   <= PWM_EDGE;
      actInvert_q <= 1'b0;
      shdPeriod_q <= '0;
      shdDuty_q   <= '0;
      shdMode_q   <= PWM_EDGE;
      shdInvert_q <= 1'b0;
      pending_q   <= 1'b0;
      cnt_q       <= '0;
      dirDown_q   <= 1'b0;
      out_q       <= 1'b0;
      periodEnd_q <= 1'b0;
`ifdef PWM_DEADTIME_EN
      dtState_q   <= DT_IDLE;
      dtCnt_q     <= '0;
      outN_q      <= 1'b0;
`endif
    end else begin
      actPeriod_q <= actPeriod_d;
      actDuty_q   <= actDuty_d;
      actMode_q   <= actMode_d;
      actInvert_q <= actInvert_d;
      shdPeriod_q <= shdPeriod_d;
      shdDuty_q   <= shdDuty_d;
      shdMode_q   <= shdMode_d;
      shdInvert_q <= shdInvert_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      dirDown_q   <= dirDown_d;
      out_q       <= out_d;
      periodEnd_q <= periodEnd_d;
`ifdef PWM_DEADTIME_EN
      dtState_q   <= dtState_d;
      dtCnt_q     <= dtCnt_d;
      outN_q      <= outN_d;
`endif
    end
  end

  assign pwm_o         = out_q;
  assign period_end_o  = periodEnd_q;
  assign upd_pending_o = pending_q;
`ifdef PWM_DEADTIME_EN
  assign pwm_n_o       = outN_q;
`endif

endmodule

// File: rtl/pwm_multi_core.sv
// pwm_multi_core: N independent PWM channels sharing one configuration bus
// and one sync input. Defining PWM_DEADTIME_EN adds the complementary
// outputs pwm_out_n with dead-time insertion.
module pwm_multi_core
  import pwm_multi_pkg::*;
#(
  parameter int N_CHANNELS   = PWM_N_CHANNELS_DEF,
  parameter int WIDTH_PERIOD = PWM_WIDTH_PERIOD_DEF,
  parameter int WIDTH_DUTY   = PWM_WIDTH_DUTY_DEF,
  parameter int DEADTIME     = PWM_DEADTIME_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CHANNELS-1:0]   ch_en,
  input  logic                    sync,
  input  logic [N_CHANNELS-1:0]   cfg_wr,
  input  logic [WIDTH_PERIOD-1:0] cfg_period,
  input  logic [WIDTH_DUTY-1:0]   cfg_duty,
  input  logic                    cfg_center,
  input  logic                    cfg_invert,
  output logic [N_CHANNELS-1:0]   pwm_out,
`ifdef PWM_DEADTIME_EN
  output logic [N_CHANNELS-1:0]   pwm_out_n,
`endif
  output logic [N_CHANNELS-1:0]   period_end,
  output logic [N_CHANNELS-1:0]   upd_pending
);

  // Channel count is limited to what a 32-bit register map can address.
  if ((N_CHANNELS < 1) || (N_CHANNELS > 32)) begin : g_bad_channels
    $error("pwm_multi_core: N_CHANNELS out of range");
  end

  // One channel per bit; sync and the config bus fan out, each channel picks its own strobe.
  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .WIDTH_PERIOD (WIDTH_PERIOD),
      .WIDTH_DUTY   (WIDTH_DUTY),
      .DEADTIME     (DEADTIME)
    ) u_ch (
      .clk_i         (clk),
      .rst_ni        (reset_n),
      .en_i          (ch_en[i]),
      .sync_i        (sync),
      .wr_i          (cfg_wr[i]),
      .period_i      (cfg_period),
      .duty_i        (cfg_duty),
      .center_i      (cfg_center),
      .invert_i      (cfg_invert),
      .pwm_o         (pwm_out[i]),
`ifdef PWM_DEADTIME_EN
      .pwm_n_o       (pwm_out_n[i]),
`endif
      .period_end_o  (period_end[i]),
      .upd_pending_o (upd_pending[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_core.sv
// tb_pwm_multi_core: directed stimulus with a scoreboard queue of expected
// per-cycle pin values, consumed by a monitor on the falling clock edge.
module tb_pwm_multi_core;
  import pwm_multi_pkg::*;

  localparam int N  = 4;
  localparam int WP = 16;
  localparam int WD = 16;
  localparam int DT = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  ch_en;
  logic          sync;
  logic [N-1:0]  cfg_wr;
  logic [WP-1:0] cfg_period;
  logic [WD-1:0] cfg_duty;
  logic          cfg_center;
  logic          cfg_invert;
  logic [N-1:0]  pwm_out;
  logic [N-1:0]  period_end;
  logic [N-1:0]  upd_pending;
`ifdef PWM_DEADTIME_EN
  logic [N-1:0]  pwm_out_n;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int    cycle;
    int    ch;
    int    kind;
    logic  expv;
    string tag;
  } exp_t;

  exp_t sbq[$];

  pwm_multi_core #(
    .N_CHANNELS   (N),
    .WIDTH_PERIOD (WP),
    .WIDTH_DUTY   (WD),
    .DEADTIME     (DT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ch_en       (ch_en),
    .sync        (sync),
    .cfg_wr      (cfg_wr),
    .cfg_period  (cfg_period),
    .cfg_duty    (cfg_duty),
    .cfg_center  (cfg_center),
    .cfg_invert  (cfg_invert),
    .pwm_out     (pwm_out),
`ifdef PWM_DEADTIME_EN
    .pwm_out_n   (pwm_out_n),
`endif
    .period_end  (period_end),
    .upd_pending (upd_pending)
  );

  // Free-running clock and a cycle index shared by stimulus and monitor.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic pickOut(input int ch, input int kind);
    case (kind)
      0:       return pwm_out[ch];
      1:       return period_end[ch];
      2:       return upd_pending[ch];
`ifdef PWM_DEADTIME_EN
      3:       return pwm_out_n[ch];
`endif
      default: return 1'bx;
    endcase
  endfunction

  function automatic string kindName(input int kind);
    case (kind)
      0:       return "pwm_out";
      1:       return "period_end";
      2:       return "upd_pending";
      default: return "pwm_out_n";
    endcase
  endfunction

  task automatic pushExp(input int cycle, input int ch, input int kind, input logic expv, input string tag);
    exp_t e;
    e.cycle = cycle;
    e.ch    = ch;
    e.kind  = kind;
    e.expv  = expv;
    e.tag   = tag;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic act;
    act = pickOut(e.ch, e.kind);
    checks++;
    if (act !== e.expv || e.cycle != cyc) begin
      failures++;
      $display("[TB] FAIL %s %s[%0d] cycle=%0d (due %0d) actual=%b expected=%b",
               e.tag, kindName(e.kind), e.ch, cyc, e.cycle, act, e.expv);
    end
  endtask

  // Monitor: every falling edge, compare and retire all entries that are due.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cycle <= cyc) begin
          checkOutput(sbq[i]);
          sbq.delete(i);
        end
      end
    end
  end

  task automatic stepClk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] wr, input int p, input int d,
                               input logic center, input logic inv);
    cfg_wr     = wr;
    cfg_period = WP'(p);
    cfg_duty   = WD'(d);
    cfg_center = center;
    cfg_invert = inv;
  endtask

  // Stop channel, load its config directly, restart; 'start' is the cycle showing counter 0.
  task automatic setupCh(input int ch, input int p, input int d, input logic center,
                         input logic inv, output int start);
    logic [N-1:0] m;
    m     = '0;
    m[ch] = 1'b1;
    ch_en[ch] = 1'b0;
    applyStimulus(m, p, d, center, inv);
    stepClk(1);
    cfg_wr    = '0;
    ch_en[ch] = 1'b1;
    start     = cyc + 1;
  endtask

  // Expected pwm_out/period_end for cycles [from, from+n) of a run that showed counter 0 at cycle s.
  task automatic pushRun(input int ch, input int s, input int from, input int n, input int p,
                         input int d, input logic center, input logic inv, input string tag);
    int   j, k, c;
    logic rawv, pe;
    for (int x = from; x < from + n; x++) begin
      j = x - s;
      if (p == 0) begin
        rawv = 1'b0;
        pe   = 1'b0;
      end else if (center) begin
        k    = j % (2 * p);
        c    = (k < p) ? k : (2 * p - 1 - k);
        rawv = (c < d);
        pe   = (k == 2 * p - 1);
      end else begin
        k    = j % p;
        rawv = (k < d);
        pe   = (k == p - 1);
      end
      pushExp(x, ch, 0, rawv ^ inv, tag);
      pushExp(x, ch, 1, pe, tag);
    end
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) stepClk(1);
  endtask

  typedef struct {
    int    p;
    int    d;
    logic  inv;
    string tag;
  } lim_t;

  initial begin
    int   s0, s1, s3, c, k3, s, ent;
    lim_t lims[7];
    pwm_cfg_t cfgA;

    reset_n = 1'b0;
    ch_en   = '0;
    sync    = 1'b0;
    applyStimulus('0, 0, 0, 1'b0, 1'b0);
    stepClk(2);

    // Reset state on every channel.
    for (int ch = 0; ch < N; ch++) begin
      for (int kd = 0; kd < 3; kd++) pushExp(cyc, ch, kd, 1'b0, "reset");
    end
    stepClk(1);
    reset_n = 1'b1;
    stepClk(1);

`ifndef PWM_DEADTIME_EN
    // Edge mode P=10 D=3 on ch0.
    cfgA = '{period: 16'd10, duty: 16'd3, center: PWM_EDGE, invert: 1'b0};
    setupCh(0, int'(cfgA.period), int'(cfgA.duty), cfgA.center, cfgA.invert, s0);
    pushRun(0, s0, s0, 25, 10, 3, 1'b0, 1'b0, "edge_p10_d3");
    for (int x = s0; x < s0 + 5; x++) pushExp(x, 0, 2, 1'b0, "edge_no_pending");
    waitUntil(s0 + 25);

    // Center mode P=8 D=2 on ch1.
    setupCh(1, 8, 2, 1'b1, 1'b0, s1);
    pushRun(1, s1, s1, 34, 8, 2, 1'b1, 1'b0, "center_p8_d2");
    waitUntil(s1 + 34);

    // Shadow update of ch0 duty mid-period (counter at 4 when the write lands).
    for (int g = 0; g < 20 && ((cyc + 1 - s0) % 10) != 4; g++) stepClk(1);
    c = cyc;
    applyStimulus(4'b0001, 10, 7, 1'b0, 1'b0);
    for (int x = c + 1; x <= c + 5; x++) pushExp(x, 0, 2, 1'b1, "shadow_pending");
    for (int x = c + 6; x <= c + 8; x++) pushExp(x, 0, 2, 1'b0, "shadow_applied");
    pushRun(0, s0, c + 1, 6, 10, 3, 1'b0, 1'b0, "shadow_old_period");
    s0 = c + 7;
    pushRun(0, s0, s0, 20, 10, 7, 1'b0, 1'b0, "shadow_new_d7");
    stepClk(1);
    cfg_wr = '0;
    waitUntil(s0 + 20);

    // Duty and period limits on ch2.
    lims[0] = '{10, 0, 1'b0, "limit_d0"};
    lims[1] = '{10, 10, 1'b0, "limit_d_eq_p"};
    lims[2] = '{10, 0, 1'b1, "limit_d0_inv"};
    lims[3] = '{10, 10, 1'b1, "limit_d_eq_p_inv"};
    lims[4] = '{1, 1, 1'b0, "limit_p1"};
    lims[5] = '{0, 5, 1'b0, "limit_p0"};
    lims[6] = '{0, 5, 1'b1, "limit_p0_inv"};
    for (int v = 0; v < 7; v++) begin
      setupCh(2, lims[v].p, lims[v].d, 1'b0, lims[v].inv, s);
      pushRun(2, s, s, 12, lims[v].p, lims[v].d, 1'b0, lims[v].inv, lims[v].tag);
      pushExp(s, 2, 2, 1'b0, lims[v].tag);
      waitUntil(s + 12);
    end

    // Sync with ch0 at its natural boundary, ch3 P=7 free-running, and a same-cycle ch3 write.
    setupCh(3, 7, 2, 1'b0, 1'b0, s3);
    stepClk(4);
    for (int g = 0; g < 20 && ((cyc + 1 - s0) % 10) != 9; g++) stepClk(1);
    c = cyc;
    sync = 1'b1;
    applyStimulus(4'b1000, 7, 4, 1'b0, 1'b0);
    k3 = (c + 1 - s3) % 7;
    pushExp(c + 1, 0, 0, 1'b0, "sync_ch0_last");
    pushExp(c + 1, 0, 1, 1'b0, "sync_ch0_no_pe");
    pushExp(c + 1, 3, 0, (k3 < 2), "sync_ch3_last");
    pushExp(c + 1, 3, 1, 1'b0, "sync_ch3_no_pe");
    pushExp(c + 1, 3, 2, 1'b0, "sync_write_wins");
    pushRun(0, c + 2, c + 2, 14, 10, 7, 1'b0, 1'b0, "sync_ch0_restart");
    pushRun(3, c + 2, c + 2, 14, 7, 4, 1'b0, 1'b0, "sync_ch3_restart");
    stepClk(1);
    sync   = 1'b0;
    cfg_wr = '0;
    waitUntil(c + 16);

    // Asynchronous reset mid-run; channels stay idle afterwards.
    reset_n = 1'b0;
    for (int ch = 0; ch < N; ch++) begin
      for (int kd = 0; kd < 3; kd++) pushExp(cyc, ch, kd, 1'b0, "reset_midrun");
    end
    stepClk(2);
    reset_n = 1'b1;
    for (int x = cyc + 1; x <= cyc + 4; x++) begin
      pushExp(x, 0, 0, 1'b0, "after_reset_idle");
      pushExp(x, 0, 1, 1'b0, "after_reset_idle");
    end
    stepClk(5);
`else
    // Dead-time: P=10 D=5 edge gives 3-clock pulses on each output with 2-clock gaps.
    setupCh(0, 10, 5, 1'b0, 1'b0, s);
    for (int x = s; x < s + 20; x++) begin
      k3 = (x - s) % 10;
      pushExp(x, 0, 0, (k3 >= 2) && (k3 < 5), "deadtime_pwm");
      pushExp(x, 0, 3, (k3 >= 7), "deadtime_pwm_n");
    end
    waitUntil(s + 20);
    for (int g = 0; g < 20 && ((cyc - s) % 10) != 3; g++) stepClk(1);
    reset_n = 1'b0;
    pushExp(cyc, 0, 0, 1'b0, "deadtime_reset");
    pushExp(cyc, 0, 3, 1'b0, "deadtime_reset");
    stepClk(2);
    reset_n = 1'b1;
    stepClk(1);
`endif

    // Drain the scoreboard with a bound; anything left over counts as a failure.
    for (int g = 0; g < 200 && sbq.size() != 0; g++) stepClk(1);
    ent = sbq.size();
    if (ent != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain entries_left=%0d required=0", ent);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
